// File: rtl/serial_cmd_rx.sv
// serial_cmd_rx: 8N1 UART receiver plus measurement-command decoder with a one-deep pending slot.
// Latency: cmd_valid rises on the edge right after the stop-bit sample (~9.5 bit times + 3 clk after the RxD fall).
// Backpressure: one command is held until ready; a valid command arriving while it is still held is dropped (overrun pulse).
//
// Ports:
//   clk        system clock (the only clock)
//   rst        synchronous active-high reset
//   RxD        asynchronous serial input, idles high
//   ready      controller can accept the pending command
//   cmd_valid  a command is pending and opcode is valid
//   opcode     2-bit opcode of the pending command
//   frame_err  1-cycle pulse: stop bit sampled low
//   bad_cmd    1-cycle pulse: good frame with wrong prefix
//   overrun    1-cycle pulse: valid command dropped because one is pending
module serial_cmd_rx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [5:0]  CMD_PREFIX   = 6'b101000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       ready,
    output logic       cmd_valid,
    output logic [1:0] opcode,
    output logic       frame_err,
    output logic       bad_cmd,
    output logic       overrun
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser presets to the idle level so reset never looks like a start bit.
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bitidx    <= '0;
            shift     <= '0;
            cmd_valid <= 1'b0;
            opcode    <= 2'd0;
            frame_err <= 1'b0;
            bad_cmd   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= RxD;
            rx_s      <= rx_meta;
            frame_err <= 1'b0;
            bad_cmd   <= 1'b0;
            overrun   <= 1'b0;

            // Transfer retires the pending command; a load later in this
            // block overrides this so a same-cycle new command wins.
            if (cmd_valid && ready)
                cmd_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s)
                        state <= START;
                end

                START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state  <= DATA;
                            bitidx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    // Sampling point is a full bit after mid-start, i.e. mid-bit.
                    if (cnt == LAST) begin
                        cnt           <= '0;
                        shift[bitidx] <= rx_s;
                        if (bitidx == 3'd7)
                            state <= STOP;
                        else
                            bitidx <= bitidx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (shift[7:2] != CMD_PREFIX) begin
                                bad_cmd <= 1'b1;
                            end else if (!cmd_valid || ready) begin
                                cmd_valid <= 1'b1;
                                opcode    <= shift[1:0];
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                BRK: begin
                    // Hold off until the line returns high so a break reports once.
                    cnt <= '0;
                    if (rx_s)
                        state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed bench for serial_cmd_rx at 16 clocks per bit.
// Outputs are sampled one time unit after the falling clock edge; inputs change one unit after the rising edge.
// Event counters in a negedge monitor feed the per-step expectations.
module tb_serial_cmd_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic       ready;
    logic       cmd_valid;
    logic [1:0] opcode;
    logic       frame_err;
    logic       bad_cmd;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // monitor counters
    int fe_n = 0, bc_n = 0, ov_n = 0, rise_n = 0, hi_n = 0, xfer_n = 0, wide_n = 0;
    logic cv_q = 1'b0, fe_q = 1'b0, bc_q = 1'b0, ov_q = 1'b0;

    // snapshots
    int b_fe, b_bc, b_ov, b_rise, b_hi, b_xfer;

    serial_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .CMD_PREFIX  (6'b101000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .ready    (ready),
        .cmd_valid(cmd_valid),
        .opcode   (opcode),
        .frame_err(frame_err),
        .bad_cmd  (bad_cmd),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_n++;
        if (bad_cmd)   bc_n++;
        if (overrun)   ov_n++;
        if (cmd_valid && !cv_q) rise_n++;
        if (cmd_valid) hi_n++;
        if (cmd_valid && ready) xfer_n++;
        if ((frame_err && fe_q) || (bad_cmd && bc_q) || (overrun && ov_q)) wide_n++;
        cv_q = cmd_valid;
        fe_q = frame_err;
        bc_q = bad_cmd;
        ov_q = overrun;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample_point();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        sample_point();
        b_fe = fe_n; b_bc = bc_n; b_ov = ov_n;
        b_rise = rise_n; b_hi = hi_n; b_xfer = xfer_n;
    endtask

    // Assumes the caller is at posedge+1.
    task automatic drive_bit(input logic v);
        RxD = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Full frame. rdy_at_stop raises ready only for the stop-sample edge
    // (start of send + 155 edges, i.e. 11th edge of the stop bit).
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic rdy_at_stop);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
        RxD = stop_v;
        repeat (10) @(posedge clk);
        #1;
        if (rdy_at_stop) ready = 1'b1;
        @(posedge clk);
        #1;
        if (rdy_at_stop) ready = 1'b0;
        repeat (CPB - 11) @(posedge clk);
        #1;
    endtask

    task automatic ready_pulse();
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        RxD   = 1'b1;
        ready = 1'b0;
        idle(3);
        sample_point();
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_opcode",    32'(opcode),    32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_bad_cmd",   32'(bad_cmd),   32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(10);

        // Basic command with ready held high: one-cycle valid
        ready = 1'b1;
        snap();
        send_byte(8'hA2, 1'b1, 1'b0);
        idle(10);
        sample_point();
        check("basic_rises",  32'(rise_n - b_rise), 32'd1);
        check("basic_hi_cyc", 32'(hi_n - b_hi),     32'd1);
        check("basic_xfer",   32'(xfer_n - b_xfer), 32'd1);
        check("basic_opcode", 32'(opcode),          32'd2);
        check("basic_cv_low", 32'(cmd_valid),       32'd0);
        check("basic_errs",   32'((fe_n - b_fe) + (bc_n - b_bc) + (ov_n - b_ov)), 32'd0);

        // Held pending for 200 cycles
        ready = 1'b0;
        send_byte(8'hA1, 1'b1, 1'b0);
        snap();
        repeat (200) @(negedge clk);
        #1;
        check("hold_hi_200", 32'(hi_n - b_hi), 32'd200);
        check("hold_cv",     32'(cmd_valid),   32'd1);
        check("hold_opcode", 32'(opcode),      32'd1);
        ready_pulse();
        sample_point();
        check("hold_release_cv", 32'(cmd_valid),       32'd0);
        check("hold_release_xf", 32'(xfer_n - b_xfer), 32'd1);

        // Overrun: second command dropped
        snap();
        send_byte(8'hA3, 1'b1, 1'b0);
        send_byte(8'hA0, 1'b1, 1'b0);
        idle(5);
        sample_point();
        check("ovr_count",  32'(ov_n - b_ov), 32'd1);
        check("ovr_opcode", 32'(opcode),      32'd3);
        check("ovr_cv",     32'(cmd_valid),   32'd1);
        ready_pulse();
        idle(50);
        sample_point();
        check("ovr_drain_cv",    32'(cmd_valid),       32'd0);
        check("ovr_drain_rises", 32'(rise_n - b_rise), 32'd1);

        // Bad prefix, then a short low glitch
        snap();
        send_byte(8'h41, 1'b1, 1'b0);
        idle(5);
        sample_point();
        check("bad_count", 32'(bc_n - b_bc), 32'd1);
        check("bad_cv",    32'(cmd_valid),   32'd0);
        snap();
        @(posedge clk);
        #1 RxD = 1'b0;
        idle(3);
        RxD = 1'b1;
        idle(40);
        sample_point();
        check("glitch_pulses", 32'((fe_n - b_fe) + (bc_n - b_bc) + (ov_n - b_ov)), 32'd0);
        check("glitch_rises",  32'(rise_n - b_rise), 32'd0);
        // Receiver must be back in idle and decode the next frame normally
        send_byte(8'hA2, 1'b1, 1'b0);
        idle(5);
        sample_point();
        check("post_glitch_cv", 32'(cmd_valid), 32'd1);
        check("post_glitch_op", 32'(opcode),    32'd2);
        ready_pulse();
        idle(5);

        // Framing error followed by a 40-bit break
        snap();
        send_byte(8'hA2, 1'b0, 1'b0);
        idle(40 * CPB);
        RxD = 1'b1;
        idle(20);
        sample_point();
        check("ferr_count", 32'(fe_n - b_fe),     32'd1);
        check("ferr_rises", 32'(rise_n - b_rise), 32'd0);
        send_byte(8'hA1, 1'b1, 1'b0);
        idle(5);
        sample_point();
        check("ferr_after_cv", 32'(cmd_valid), 32'd1);
        check("ferr_after_op", 32'(opcode),    32'd1);
        ready_pulse();
        idle(5);

        // Reset during data bit 4, with a command pending
        send_byte(8'hA3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        RxD = 1'b0;
        idle(CPB / 2);
        rst = 1'b1;
        RxD = 1'b1;
        idle(1);
        sample_point();
        check("midrst_cv",  32'(cmd_valid), 32'd0);
        check("midrst_op",  32'(opcode),    32'd0);
        check("midrst_err", 32'({frame_err, bad_cmd, overrun}), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(20);
        snap();
        send_byte(8'hA2, 1'b1, 1'b0);
        idle(5);
        sample_point();
        check("postrst_cv",   32'(cmd_valid), 32'd1);
        check("postrst_op",   32'(opcode),    32'd2);
        check("postrst_errs", 32'((fe_n - b_fe) + (bc_n - b_bc) + (ov_n - b_ov)), 32'd0);
        ready_pulse();
        idle(5);

        // Transfer and new load in the same cycle
        send_byte(8'hA3, 1'b1, 1'b0);
        snap();
        send_byte(8'hA0, 1'b1, 1'b1);
        idle(3);
        sample_point();
        check("simul_cv",    32'(cmd_valid),       32'd1);
        check("simul_op",    32'(opcode),          32'd0);
        check("simul_ovr",   32'(ov_n - b_ov),     32'd0);
        check("simul_xfer",  32'(xfer_n - b_xfer), 32'd1);
        check("simul_rises", 32'(rise_n - b_rise), 32'd0);

        check("pulse_width", 32'(wide_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_cmd_rx.md
Name: serial_cmd_rx

Overview:
UART receiver and command decoder on the host-to-meter direction of the serial link. It deserialises 8N1 frames on RxD, validates each byte as a measurement command, and presents a 2-bit opcode to the top controller through a valid/ready handshake. It holds one pending command, so a command arriving while the controller is busy is not lost.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range is >= 4.
CMD_PREFIX, 6'b101000, upper 6 bits a byte must carry to be a valid command.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
RxD  in  1  asynchronous serial input; idles high.
ready  in  1  controller can accept a command (controller's ready output).
cmd_valid  out  1  a command is pending; opcode is valid.
opcode  out  2  pending command opcode; feeds controller opcode.
frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
bad_cmd  out  1  one-cycle pulse when a good frame fails prefix check.
overrun  out  1  one-cycle pulse when a valid command is dropped because one is already pending.

Behaviour:
- Reset (rst high at a clk edge):
  - FSM goes to IDLE; bit counter and baud counter are cleared.
  - cmd_valid=0, opcode=0, frame_err=0, bad_cmd=0, overrun=0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame abandons the frame; nothing is reported.
- RxD passes through a 2-FF synchroniser (rx_s), adding 2 cycles of latency. All decisions use rx_s.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on entry to each state.
- FSM:
  - IDLE: rx_s==0 -> START.
  - START: at count == CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s. If 0 -> DATA with bit index 0. If 1 -> IDLE (glitch rejected, no pulse).
  - DATA: at count == CLKS_PER_BIT-1, shift rx_s into shift[bitidx], LSB first. After bit 7 -> STOP; otherwise bitidx++.
  - STOP: at count == CLKS_PER_BIT-1, sample rx_s.
    - If 1: byte done -> IDLE.
    - If 0: pulse frame_err, discard the byte -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. A held-low line therefore yields exactly one frame_err.
- Byte done, evaluated in the same cycle as the stop sample; outputs update on the next edge:
  - shift[7:2] != CMD_PREFIX: pulse bad_cmd; pending state unchanged.
  - Prefix matches and (cmd_valid==0, or cmd_valid==1 and ready==1 in that cycle): cmd_valid<=1, opcode<=shift[1:0].
  - Prefix matches, cmd_valid==1 and ready==0: pulse overrun; the pending command is kept and the new one dropped.
- Handshake:
  - Transfer occurs on any edge where cmd_valid && ready.
  - After a transfer, cmd_valid<=0 unless a new command loads in the same cycle; a simultaneous load wins and cmd_valid stays 1.
  - opcode is stable while cmd_valid=1 and no transfer occurs.
  - ready while cmd_valid=0 has no effect.
- Latency: cmd_valid rises 1 cycle after the stop-bit sample cycle. That is about 9.5 bit times plus 3 cycles after the RxD falling edge.
- Back-to-back frames: a start bit may begin in the cycle right after the STOP -> IDLE transition; no idle gap is required.
- Error pulses are exactly one cycle wide. At most one of frame_err, bad_cmd and overrun pulses per frame.

Test Plan:
- Basic command: CLKS_PER_BIT=16, ready=1, send 0xA2 -> one cycle with cmd_valid=1, opcode=2, then cmd_valid=0. No error pulses.
- Held pending: ready=0, send 0xA1 -> cmd_valid=1, opcode=1 held for 200 cycles. Then raise ready for 1 cycle -> cmd_valid=0 on the next edge.
- Overrun: ready=0, send 0xA3 then 0xA0 -> overrun pulses once; opcode stays 3. Then raise ready -> cmd_valid drops and no new command appears.
- Bad command and glitch:
  - Send 0x41 -> bad_cmd pulses once; cmd_valid stays 0.
  - Drive a 3-cycle low glitch on RxD -> no pulses, FSM returns to IDLE.
- Framing error: send 0xA2 with stop bit low, then hold RxD low for 40 bits -> frame_err pulses exactly once. Release and send 0xA1 -> opcode=1 accepted.
- Reset and simultaneity:
  - Assert rst at data bit 4 -> all outputs 0. The next 0xA2 is received correctly.
  - With 0xA3 pending, a new 0xA0 arrives with ready=1 in the stop-sample cycle -> cmd_valid stays 1, opcode=0, no overrun.
